temp_frame_rx: RTL and testbench

UART receive-side decoder for the ASCII temperature frame that the board's temperature/UART transmit path emits. It deserialises the `rx` line at a fixed baud rate and parses frames of the form "temp:" [ '-' ] [D4] D3 D2 '.' D1 D0, where D4 is present only when nonzero and there is no terminator. It outputs the reconstructed 14-bit magnitude (units of 0.01 °C) and sign. It sits at the board's UART input, so a second board, or a loopback, can consume the same stream the display/UART path produces.

---
 rtl/temp_frame_pkg.sv | 58 +++++
 rtl/temp_frame_rx_uart.sv | 101 ++++++++++
 rtl/temp_frame_rx.sv | 173 +++++++++++++++++
 tb/tb_temp_frame_rx.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_frame_pkg.sv
// Shared constants, state types and arithmetic helpers for the temperature frame receiver.
package temp_frame_pkg;

    localparam int TEMP_W   = 14;
    localparam int TEMP_MAX = 16383;
    localparam int ACC_W    = 17;

    localparam logic [ACC_W-1:0] ACC_LIMIT = ACC_W'(TEMP_MAX);

    localparam logic [7:0] CH_T     = 8'h74;
    localparam logic [7:0] CH_E     = 8'h65;
    localparam logic [7:0] CH_M     = 8'h6d;
    localparam logic [7:0] CH_P     = 8'h70;
    localparam logic [7:0] CH_COLON = 8'h3a;
    localparam logic [7:0] CH_MINUS = 8'h2d;
    localparam logic [7:0] CH_DOT   = 8'h2e;
    localparam logic [7:0] CH_ZERO  = 8'h30;

    typedef enum logic [2:0] {
        P_IDLE,
        P_HDR,
        P_SIGN,
        P_INT,
        P_FRAC,
        P_DONE
    } parse_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_ZERO) && (b <= 8'h39);
    endfunction

    // acc*10 + digit using shifts only; callers keep acc small enough that nothing is lost
    function automatic logic [ACC_W-1:0] mac10(input logic [ACC_W-1:0] acc, input logic [7:0] b);
        logic [7:0] d;
        d = b - CH_ZERO;
        return (acc << 3) + (acc << 1) + {{(ACC_W-8){1'b0}}, d};
    endfunction

    // Expected header character after the leading 't' (index 1..4)
    function automatic logic [7:0] hdr_char(input logic [2:0] idx);
        logic [7:0] c;
        case (idx)
            3'd1:    c = CH_E;
            3'd2:    c = CH_M;
            3'd3:    c = CH_P;
            default: c = CH_COLON;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/temp_frame_rx_uart.sv
// 8N1 UART byte receiver: synchroniser, mid-bit sampling, stop-bit check.
module uart_rx_byte
    import temp_frame_pkg::*;
#(
    parameter int BIT_CYC = 434
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_vld,
    output logic       byte_err
);

    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CW       = $clog2(BIT_CYC + 1);

    // rx_sync[1] is the synchronised line, rx_sync[2] its previous value for edge detection
    logic [2:0]    rx_sync;
    logic          rx_cur;
    logic          rx_prev;
    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    assign rx_cur  = rx_sync[1];
    assign rx_prev = rx_sync[2];

    // Synchronise the asynchronous line; idles high so reset to ones
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_sync <= 3'b111;
        end else begin
            rx_sync <= {rx_sync[1:0], rx};
        end
    end

    // Start detect, half-bit alignment, 8 data bits LSB first, then stop-bit check
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= R_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            byte_data <= '0;
            byte_vld  <= 1'b0;
            byte_err  <= 1'b0;
        end else begin
            byte_vld <= 1'b0;
            byte_err <= 1'b0;
            unique case (state)
                R_IDLE: begin
                    if (rx_prev && !rx_cur) begin
                        state <= R_START;
                        cnt   <= CW'(HALF_CYC - 1);
                    end
                end
                R_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (rx_cur) begin
                        state <= R_IDLE;
                    end else begin
                        state   <= R_DATA;
                        cnt     <= CW'(BIT_CYC - 1);
                        bit_idx <= '0;
                    end
                end
                R_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        shreg <= {rx_cur, shreg[7:1]};
                        cnt   <= CW'(BIT_CYC - 1);
                        if (bit_idx == 3'd7) begin
                            state <= R_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                R_STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        if (rx_cur) begin
                            byte_vld  <= 1'b1;
                            byte_data <= shreg;
                        end else begin
                            byte_err <= 1'b1;
                        end
                        state <= R_IDLE;
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/temp_frame_rx.sv
// Parses "temp:[-][D4]D3D2.D1D0" frames from the UART byte stream into magnitude and sign.
//
// state  | meaning
// IDLE   | waiting for 't'
// HDR    | matching "emp:"
// SIGN   | optional '-' or first integer digit
// INT    | integer digits, then '.' after 2 or 3 digits
// FRAC   | exactly two fraction digits
// DONE   | range check and result publish
module temp_frame_rx
    import temp_frame_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int TIMEOUT_CYC = 100_000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              rx,
    output logic [TEMP_W-1:0] temp_data,
    output logic              temp_sign,
    output logic              temp_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int BIT_CYC = CLK_FREQ / BAUD;
    localparam int TW      = $clog2(TIMEOUT_CYC + 1);

    logic [7:0]       byte_data;
    logic             byte_vld;
    logic             byte_err;

    parse_state_t     state;
    logic [2:0]       hdr_idx;
    logic [1:0]       int_cnt;
    logic             frac_cnt;
    logic             sign_r;
    logic [ACC_W-1:0] acc;
    logic [TW-1:0]    tmr;
    logic             byte_ok;

    uart_rx_byte #(
        .BIT_CYC (BIT_CYC)
    ) u_rx (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx        (rx),
        .byte_data (byte_data),
        .byte_vld  (byte_vld),
        .byte_err  (byte_err)
    );

    assign busy = (state != P_IDLE);

    // Whether the current byte is legal for the state it arrives in
    always_comb begin
        byte_ok = 1'b0;
        unique case (state)
            P_HDR:   byte_ok = (byte_data == hdr_char(hdr_idx));
            P_SIGN:  byte_ok = (byte_data == CH_MINUS) || is_digit(byte_data);
            P_INT:   byte_ok = (is_digit(byte_data) && (int_cnt != 2'd3)) ||
                               ((byte_data == CH_DOT) && (int_cnt >= 2'd2));
            P_FRAC:  byte_ok = is_digit(byte_data);
            default: byte_ok = 1'b0;
        endcase
    end

    // Parser FSM with inter-byte timeout; the timer is preloaded so the abort pulse
    // lands exactly TIMEOUT_CYC cycles after the last byte_vld
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= P_IDLE;
            hdr_idx    <= '0;
            int_cnt    <= '0;
            frac_cnt   <= 1'b0;
            sign_r     <= 1'b0;
            acc        <= '0;
            tmr        <= '0;
            temp_data  <= '0;
            temp_sign  <= 1'b0;
            temp_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            temp_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (byte_vld) begin
                tmr <= TW'(TIMEOUT_CYC - 2);
            end else if ((state != P_IDLE) && (tmr != '0)) begin
                tmr <= tmr - TW'(1);
            end

            unique case (state)
                P_IDLE: begin
                    if (byte_vld && (byte_data == CH_T)) begin
                        state   <= P_HDR;
                        hdr_idx <= 3'd1;
                    end
                end
                P_DONE: begin
                    if (acc <= ACC_LIMIT) begin
                        temp_data  <= acc[TEMP_W-1:0];
                        temp_sign  <= sign_r;
                        temp_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                    state <= P_IDLE;
                end
                default: begin
                    if (byte_err) begin
                        frame_err <= 1'b1;
                        state     <= P_IDLE;
                    end else if (byte_vld && !byte_ok) begin
                        frame_err <= 1'b1;
                        // a stray 't' is most likely the start of the next frame
                        if (byte_data == CH_T) begin
                            state   <= P_HDR;
                            hdr_idx <= 3'd1;
                        end else begin
                            state <= P_IDLE;
                        end
                    end else if (byte_vld) begin
                        unique case (state)
                            P_HDR: begin
                                if (hdr_idx == 3'd4) begin
                                    state <= P_SIGN;
                                end else begin
                                    hdr_idx <= hdr_idx + 3'd1;
                                end
                            end
                            P_SIGN: begin
                                state <= P_INT;
                                if (byte_data == CH_MINUS) begin
                                    sign_r  <= 1'b1;
                                    acc     <= '0;
                                    int_cnt <= 2'd0;
                                end else begin
                                    sign_r  <= 1'b0;
                                    acc     <= mac10('0, byte_data);
                                    int_cnt <= 2'd1;
                                end
                            end
                            P_INT: begin
                                if (byte_data == CH_DOT) begin
                                    state    <= P_FRAC;
                                    frac_cnt <= 1'b0;
                                end else begin
                                    acc     <= mac10(acc, byte_data);
                                    int_cnt <= int_cnt + 2'd1;
                                end
                            end
                            P_FRAC: begin
                                acc <= mac10(acc, byte_data);
                                if (frac_cnt) begin
                                    state <= P_DONE;
                                end else begin
                                    frac_cnt <= 1'b1;
                                end
                            end
                            default: state <= P_IDLE;
                        endcase
                    end else if (tmr == '0) begin
                        frame_err <= 1'b1;
                        state     <= P_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_temp_frame_rx.sv
// Scoreboard bench: a string-level grammar model predicts each frame outcome, a monitor checks the DUT pulses.
module tb_temp_frame_rx;

    localparam int BAUD  = 115200;
    localparam int BITC  = 8;
    localparam int CLKF  = BAUD * BITC;
    localparam int TMO   = 400;

    localparam int EV_VALID = 0;
    localparam int EV_ERR   = 1;
    localparam int EV_TMO   = 2;

    typedef byte unsigned bq_t[$];
    typedef struct {
        int kind;
        int data;
        bit sign;
    } ev_t;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        rx;
    logic [13:0] temp_data;
    logic        temp_sign;
    logic        temp_valid;
    logic        frame_err;
    logic        busy;

    ev_t  exp_q[$];
    bq_t  mbuf;
    int   last_data;
    bit   last_sign;
    int   checks;
    int   errors;
    int   cyc;
    int   last_bv;

    temp_frame_rx #(
        .CLK_FREQ    (CLKF),
        .BAUD        (BAUD),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .rx         (rx),
        .temp_data  (temp_data),
        .temp_sign  (temp_sign),
        .temp_valid (temp_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model: grammar over the frame text ----------------
    function automatic bit is_dig(input byte unsigned c);
        return (c >= "0") && (c <= "9");
    endfunction

    function automatic bit valid_prefix(input bq_t s);
        string hdr;
        int    n, p, nd, nf;
        hdr = "temp:";
        n   = s.size();
        for (int i = 0; i < 5 && i < n; i++)
            if (s[i] != hdr[i]) return 1'b0;
        if (n <= 5) return 1'b1;
        p = 5;
        if (s[p] == "-") p++;
        nd = 0;
        while (p < n && is_dig(s[p])) begin nd++; p++; end
        if (nd > 3) return 1'b0;
        if (p == n) return 1'b1;
        if (s[p] != "." || nd < 2) return 1'b0;
        p++;
        nf = 0;
        while (p < n && is_dig(s[p])) begin nf++; p++; end
        return (nf <= 2) && (p == n);
    endfunction

    function automatic int frame_value(input bq_t s);
        int v;
        v = 0;
        for (int i = 5; i < s.size(); i++)
            if (is_dig(s[i])) v = v * 10 + int'(s[i] - 8'd48);
        return v;
    endfunction

    function automatic void push_ev(input int kind, input int data, input bit sign);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.sign = sign;
        exp_q.push_back(e);
    endfunction

    function automatic void model_byte(input byte unsigned b);
        bq_t cand;
        int  v;
        if (mbuf.size() == 0) begin
            if (b == "t") mbuf.push_back(b);
        end else begin
            cand = mbuf;
            cand.push_back(b);
            if (valid_prefix(cand)) begin
                if (cand.size() >= 8 && cand[cand.size()-3] == ".") begin
                    v = frame_value(cand);
                    if (v <= 16383) begin
                        last_data = v;
                        last_sign = (cand[5] == "-");
                        push_ev(EV_VALID, last_data, last_sign);
                    end else begin
                        push_ev(EV_ERR, last_data, last_sign);
                    end
                    mbuf.delete();
                end else begin
                    mbuf = cand;
                end
            end else begin
                push_ev(EV_ERR, last_data, last_sign);
                mbuf.delete();
                if (b == "t") mbuf.push_back(b);
            end
        end
    endfunction

    function automatic void model_berr();
        if (mbuf.size() != 0) begin
            push_ev(EV_ERR, last_data, last_sign);
            mbuf.delete();
        end
    endfunction

    // ---------------- stimulus ----------------
    task automatic send_byte(input byte unsigned b, input bit bad_stop);
        if (bad_stop) model_berr();
        else          model_byte(b);
        @(negedge sys_clk);
        rx = 1'b0;
        repeat (BITC) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BITC) @(negedge sys_clk);
        end
        rx = !bad_stop;
        repeat (BITC) @(negedge sys_clk);
        rx = 1'b1;
        repeat ($urandom_range(1, 30)) @(negedge sys_clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
    endtask

    task automatic idle_long();
        if (mbuf.size() != 0) begin
            push_ev(EV_TMO, last_data, last_sign);
            mbuf.delete();
        end
        repeat (TMO + 50) @(negedge sys_clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge sys_clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge sys_clk) begin
        ev_t e;
        cyc++;
        if (sys_rst_n) begin
            if (dut.u_rx.byte_vld) last_bv = cyc;
            if (temp_valid || frame_err) begin
                chk("pulse_overlap", int'(temp_valid && frame_err), 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got valid=%0d err=%0d expected none", temp_valid, frame_err);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind_valid", int'(temp_valid), int'(e.kind == EV_VALID));
                    chk("temp_data", int'(temp_data), e.data);
                    chk("temp_sign", int'(temp_sign), int'(e.sign));
                    if (e.kind == EV_VALID) chk("valid_latency", cyc - last_bv, 2);
                    if (e.kind == EV_TMO) begin
                        chk("timeout_latency", cyc - last_bv, TMO);
                        chk("busy_after_timeout", int'(busy), 0);
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        string pool;
        string s;
        int    kind, v, pos;
        bit    neg;

        checks = 0; errors = 0; cyc = 0; last_bv = 0;
        last_data = 0; last_sign = 1'b0;
        rx = 1'b1;
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_temp_data", int'(temp_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(temp_valid), 0);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);

        send_str("temp:25.00");
        send_str("temp:-05.62");
        send_str("temp:163.83");
        send_str("temp:170.00");
        send_str("temp:1234");
        send_str("tetemp:12.34");

        // short low glitch must not produce a byte
        @(negedge sys_clk);
        rx = 1'b0;
        repeat (2) @(negedge sys_clk);
        rx = 1'b1;
        repeat (40) @(negedge sys_clk);

        send_str("temp:12");
        idle_long();
        chk("busy_idle", int'(busy), 0);

        send_str("temp:");
        send_byte(8'h31, 1'b1);

        send_str("temp:4");
        drain("drain_before_reset");
        chk("busy_mid_frame", int'(busy), 1);
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst2_temp_data", int'(temp_data), 0);
        chk("rst2_temp_sign", int'(temp_sign), 0);
        chk("rst2_valid", int'(temp_valid), 0);
        chk("rst2_err", int'(frame_err), 0);
        chk("rst2_busy", int'(busy), 0);
        mbuf.delete();
        last_data = 0;
        last_sign = 1'b0;
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        send_str("temp:99.99");

        pool = "tep:-.09x";
        for (int f = 0; f < 18; f++) begin
            kind = $urandom_range(0, 9);
            v    = (kind < 6) ? $urandom_range(0, 16383) : $urandom_range(16384, 99999);
            neg  = $urandom_range(0, 1);
            s    = $sformatf("temp:%s%02d.%02d", neg ? "-" : "", v / 100, v % 100);
            if (kind == 8) begin
                pos = $urandom_range(0, s.len() - 1);
                s.putc(pos, pool[$urandom_range(0, pool.len() - 1)]);
            end
            if (kind == 9) begin
                pos = $urandom_range(1, s.len() - 1);
                for (int i = 0; i < pos; i++) send_byte(s[i], 1'b0);
                send_byte(8'(($urandom_range(0, 255))), 1'b1);
            end else begin
                if ($urandom_range(0, 3) == 0) send_str("xq");
                send_str(s);
            end
        end
        idle_long();
        drain("final_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
